// File: rtl/dmux8way_buffered.sv
// Registered 1-to-8 word demultiplexer with a one-entry valid/ready holding register per channel.
// Each channel stalls independently; a drain and a reload of the same channel may share a cycle.
module dmux8way_buffered #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic [2:0]       sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] e,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] h,
   output logic [7:0]       out_valid,
   input  logic [7:0]       out_ready,
   output logic [3:0]       occupancy
);

   logic [WIDTH-1:0] data_q [8];
   logic [WIDTH-1:0] data_d [8];
   logic [7:0]       valid_q, valid_d;
   logic [3:0]       occ_q, occ_d;
   logic [7:0]       load, drain, drain_only;
   logic [3:0]       drain_cnt;
   logic             accept, load_into_empty;

   // A full channel can still accept if its consumer empties it this same cycle.
   assign in_ready = ~valid_q[sel] | out_ready[sel];
   assign accept   = in_valid & in_ready;

   always_comb begin
      load = 8'h00;
      if (accept) begin
         load[sel] = 1'b1;
      end
      drain           = valid_q & out_ready;
      drain_only      = drain & ~load;
      load_into_empty = accept & ~valid_q[sel];

      drain_cnt = 4'd0;
      for (int k = 0; k < 8; k++) begin
         drain_cnt = drain_cnt + {3'b000, drain_only[k]};
      end

      valid_d = (valid_q & ~drain) | load;
      occ_d   = occ_q + {3'b000, load_into_empty} - drain_cnt;

      // Drained channels keep their last word; only a load overwrites data.
      for (int k = 0; k < 8; k++) begin
         data_d[k] = data_q[k];
      end
      if (accept) begin
         data_d[sel] = in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 8'h00;
         occ_q   <= 4'd0;
         for (int k = 0; k < 8; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int k = 0; k < 8; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign a         = data_q[0];
   assign b         = data_q[1];
   assign c         = data_q[2];
   assign d         = data_q[3];
   assign e         = data_q[4];
   assign f         = data_q[5];
   assign g         = data_q[6];
   assign h         = data_q[7];
   assign out_valid = valid_q;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_dmux8way_buffered.sv
// Scoreboard bench for dmux8way_buffered: accepted words are queued when driven and checked
// against the addressed channel one cycle later.
module tb_dmux8way_buffered;

   logic        clk;
   logic        reset;
   logic [15:0] in;
   logic [2:0]  sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b, c, d, e, f, g, h;
   logic [7:0]  out_valid;
   logic [7:0]  out_ready;
   logic [3:0]  occupancy;

   dmux8way_buffered #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .e         (e),
      .f         (f),
      .g         (g),
      .h         (h),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  ch;
      logic [15:0] data;
   } sb_t;

   sb_t         sb [$];
   logic [7:0]  mvalid;
   int          total = 0;
   int          bad = 0;
   logic        last_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] chan(input int k);
      case (k)
         0: chan = a;
         1: chan = b;
         2: chan = c;
         3: chan = d;
         4: chan = e;
         5: chan = f;
         6: chan = g;
         default: chan = h;
      endcase
   endfunction

   function automatic logic [3:0] popcnt(input logic [7:0] v);
      popcnt = 4'd0;
      for (int k = 0; k < 8; k++) popcnt = popcnt + {3'b000, v[k]};
   endfunction

   // One clock: drive, check in_ready, predict, clock, then check the DUT response.
   task automatic cyc(input logic v, input logic [2:0] s, input logic [15:0] dat,
                      input logic [7:0] r);
      logic       exp_rdy;
      logic       acc;
      logic [7:0] drn;
      sb_t        ent;
      in_valid  = v;
      sel       = s;
      in        = dat;
      out_ready = r;
      #1;
      exp_rdy  = ~mvalid[s] | r[s];
      last_rdy = in_ready;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      acc = v & exp_rdy;
      drn = mvalid & r;
      if (acc) sb.push_back('{ch: s, data: dat});
      @(posedge clk);
      mvalid = mvalid & ~drn;
      if (acc) mvalid[s] = 1'b1;
      #1;
      if (sb.size() > 0) begin
         ent = sb.pop_front();
         check("sb_data", {16'd0, chan(int'(ent.ch))}, {16'd0, ent.data});
         check("sb_valid", {31'd0, out_valid[ent.ch]}, 32'd1);
      end
      check("out_valid", {24'd0, out_valid}, {24'd0, mvalid});
      check("occupancy", {28'd0, occupancy}, {28'd0, popcnt(mvalid)});
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      mvalid = 8'h00;
      sb.delete();
      sel    = 3'd0;
      out_ready = 8'h00;
      #1;
      check("rst_valid", {24'd0, out_valid}, 32'd0);
      check("rst_occ", {28'd0, occupancy}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      for (int k = 0; k < 8; k++) check("rst_data", {16'd0, chan(k)}, 32'd0);
   endtask

   logic [15:0] sweep [8];

   initial begin
      reset     = 1'b1;
      in        = 16'd0;
      sel       = 3'd0;
      in_valid  = 1'b0;
      out_ready = 8'h00;
      mvalid    = 8'h00;
      sweep = '{16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF, 16'hCCCC, 16'hF0F0, 16'hFF00, 16'hE38E};

      // Reset, load some channels, reset again mid-flight.
      do_reset();
      cyc(1'b1, 3'd1, 16'h1111, 8'h00);
      cyc(1'b1, 3'd4, 16'h4444, 8'h00);
      cyc(1'b1, 3'd6, 16'h6666, 8'h00);
      do_reset();

      // Route sweep into all channels with no consumer ready.
      for (int k = 0; k < 8; k++) cyc(1'b1, 3'(k), sweep[k], 8'h00);
      check("sweep_valid", {24'd0, out_valid}, 32'hFF);
      check("sweep_occ", {28'd0, occupancy}, 32'd8);

      // Backpressure on channel 2, then release in the same cycle as the load.
      cyc(1'b1, 3'd2, 16'h1234, 8'h00);
      check("bp_ready", {31'd0, last_rdy}, 32'd0);
      check("bp_hold", {16'd0, c}, 32'hAAAA);
      cyc(1'b1, 3'd2, 16'h1234, 8'h04);
      check("bp_ready_up", {31'd0, last_rdy}, 32'd1);
      check("bp_c", {16'd0, c}, 32'h1234);
      check("bp_occ", {28'd0, occupancy}, 32'd8);

      // Isolation: channel 2 stays blocked while channel 3 drains and reloads.
      cyc(1'b1, 3'd3, 16'hBEEF, 8'h08);
      check("iso_ready", {31'd0, last_rdy}, 32'd1);
      check("iso_d", {16'd0, d}, 32'hBEEF);
      check("iso_c", {16'd0, c}, 32'h1234);

      // Drain everything with no loads; data must be retained.
      cyc(1'b0, 3'd0, 16'h0000, 8'hFF);
      check("drain_valid", {24'd0, out_valid}, 32'd0);
      check("drain_occ", {28'd0, occupancy}, 32'd0);
      check("keep_a", {16'd0, a}, 32'h0000);
      check("keep_b", {16'd0, b}, 32'h5555);
      check("keep_c", {16'd0, c}, 32'h1234);
      check("keep_d", {16'd0, d}, 32'hBEEF);
      check("keep_h", {16'd0, h}, 32'hE38E);

      // Streaming one word per cycle into channel 7 with an always-ready consumer.
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b1, 3'd7, 16'(k), 8'h80);
         check("stream_v7", {31'd0, out_valid[7]}, 32'd1);
         check("stream_h", {16'd0, h}, k);
      end
      cyc(1'b0, 3'd7, 16'h0000, 8'h80);
      check("stream_end", {24'd0, out_valid}, 32'd0);
      check("sb_empty", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
